// File: rtl/ntt_butterfly.sv
// ---------------------------------------------------------------------------
// ntt_butterfly
//   Three-stage pipelined radix-2 butterfly for the NTT datapath.
//   inv_i = 0 : Cooley-Tukey    x = u + v*w,      y = u - v*w      (mod q)
//   inv_i = 1 : Gentleman-Sande x = u + v,        y = (u - v)*w    (mod q)
//   q is Q0 (select_i = 0) or Q1 (select_i = 1). It is chosen per pair, and
//   the choice travels down the pipe with the data.
//
// Ports
//   clk_i, rst_n_i          clock (rising edge), async active-low reset
//   in_valid_i/in_ready_o   input handshake for the pair {u_i, v_i, w_i}
//   select_i, inv_i         per-pair modulus select and butterfly mode
//   out_valid_o/out_ready_i output handshake for {x_o, y_o}
//
// All stages advance together when the output register is empty or being
// consumed. Otherwise the whole pipe freezes.
// ---------------------------------------------------------------------------
module ntt_butterfly #(
  parameter int unsigned W  = 23,
  parameter int unsigned Q0 = 8380417,
  parameter int unsigned Q1 = 3329
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] u_i,
  input  logic [W-1:0] v_i,
  input  logic [W-1:0] w_i,
  input  logic         select_i,
  input  logic         inv_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] x_o,
  output logic [W-1:0] y_o
);

  localparam logic [W-1:0]   Q0_W = W'(Q0);
  localparam logic [W-1:0]   Q1_W = W'(Q1);
  localparam logic [2*W-1:0] Q0_P = (2*W)'(Q0);
  localparam logic [2*W-1:0] Q1_P = (2*W)'(Q1);

  // -------------------------------------------------------------------------
  // Modular arithmetic helpers
  // -------------------------------------------------------------------------
  function automatic logic [W-1:0] q_of(input logic sel);
    return sel ? Q1_W : Q0_W;
  endfunction

  // Operands are < q, so a single conditional subtract is enough.
  function automatic logic [W-1:0] mod_add(input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input logic         sel);
    logic [W:0] sum;
    logic [W:0] qe;
    sum = {1'b0, a} + {1'b0, b};
    qe  = {1'b0, q_of(sel)};
    if (sum >= qe) sum = sum - qe;
    return sum[W-1:0];
  endfunction

  function automatic logic [W-1:0] mod_sub(input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input logic         sel);
    if (a < b) return W'({1'b0, a} + {1'b0, q_of(sel)} - {1'b0, b});
    return a - b;
  endfunction

  // This is the same product reduction that mod_mul performs. Each call site
  // below elaborates to its own multiplier (instances A and B).
  function automatic logic [W-1:0] mod_mul(input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input logic         sel);
    logic [2*W-1:0] prod;
    prod = a * b;
    return sel ? W'(prod % Q1_P) : W'(prod % Q0_P);
  endfunction

  // -------------------------------------------------------------------------
  // Pipeline registers
  // -------------------------------------------------------------------------
  logic         s1_valid_q, s1_valid_d;
  logic [W-1:0] s1_u_q,     s1_u_d;
  logic [W-1:0] s1_v_q,     s1_v_d;
  logic [W-1:0] s1_w_q,     s1_w_d;
  logic         s1_sel_q,   s1_sel_d;
  logic         s1_inv_q,   s1_inv_d;

  // Stage 2 holds {u, t} for CT and {s, d} for GS in the same a/b slots.
  logic         s2_valid_q, s2_valid_d;
  logic [W-1:0] s2_a_q,     s2_a_d;
  logic [W-1:0] s2_b_q,     s2_b_d;
  logic [W-1:0] s2_w_q,     s2_w_d;
  logic         s2_sel_q,   s2_sel_d;
  logic         s2_inv_q,   s2_inv_d;

  logic         out_valid_q, out_valid_d;
  logic [W-1:0] x_q,         x_d;
  logic [W-1:0] y_q,         y_d;

  logic         en;

  // Global advance: the output slot is free or is being drained.
  assign en          = !out_valid_q | out_ready_i;
  assign in_ready_o  = en;
  assign out_valid_o = out_valid_q;
  assign x_o         = x_q;
  assign y_o         = y_q;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every _d gets a hold default first. Paths that skip an
    // assignment then keep the register value and cannot infer a latch.
    s1_valid_d  = s1_valid_q;
    s1_u_d      = s1_u_q;
    s1_v_d      = s1_v_q;
    s1_w_d      = s1_w_q;
    s1_sel_d    = s1_sel_q;
    s1_inv_d    = s1_inv_q;
    s2_valid_d  = s2_valid_q;
    s2_a_d      = s2_a_q;
    s2_b_d      = s2_b_q;
    s2_w_d      = s2_w_q;
    s2_sel_d    = s2_sel_q;
    s2_inv_d    = s2_inv_q;
    out_valid_d = out_valid_q;
    x_d         = x_q;
    y_d         = y_q;

    if (en) begin
      // Stage 1: capture the pair. in_valid_i = 0 inserts a bubble.
      s1_valid_d = in_valid_i;
      s1_u_d     = u_i;
      s1_v_d     = v_i;
      s1_w_d     = w_i;
      s1_sel_d   = select_i;
      s1_inv_d   = inv_i;

      // Stage 2: CT multiplies v*w (instance A). GS does the add/sub.
      s2_valid_d = s1_valid_q;
      s2_w_d     = s1_w_q;
      s2_sel_d   = s1_sel_q;
      s2_inv_d   = s1_inv_q;
      if (s1_inv_q) begin
        s2_a_d = mod_add(s1_u_q, s1_v_q, s1_sel_q);
        s2_b_d = mod_sub(s1_u_q, s1_v_q, s1_sel_q);
      end else begin
        s2_a_d = s1_u_q;
        s2_b_d = mod_mul(s1_v_q, s1_w_q, s1_sel_q);
      end

      // Stage 3: CT does the add/sub. GS multiplies d*w (instance B).
      out_valid_d = s2_valid_q;
      if (s2_inv_q) begin
        x_d = s2_a_q;
        y_d = mod_mul(s2_b_q, s2_w_q, s2_sel_q);
      end else begin
        x_d = mod_add(s2_a_q, s2_b_q, s2_sel_q);
        y_d = mod_sub(s2_a_q, s2_b_q, s2_sel_q);
      end
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  // NOTE: the data registers are reset along with the valid flags so that
  // x_o/y_o read 0 out of reset. Only the valid flags carry meaning.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_valid_q  <= 1'b0;
      s1_u_q      <= '0;
      s1_v_q      <= '0;
      s1_w_q      <= '0;
      s1_sel_q    <= 1'b0;
      s1_inv_q    <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_a_q      <= '0;
      s2_b_q      <= '0;
      s2_w_q      <= '0;
      s2_sel_q    <= 1'b0;
      s2_inv_q    <= 1'b0;
      out_valid_q <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
    end else begin
      // NOTE: non-blocking updates, so every stage reads the pre-edge values
      // of the stage before it, whatever the statement order.
      s1_valid_q  <= s1_valid_d;
      s1_u_q      <= s1_u_d;
      s1_v_q      <= s1_v_d;
      s1_w_q      <= s1_w_d;
      s1_sel_q    <= s1_sel_d;
      s1_inv_q    <= s1_inv_d;
      s2_valid_q  <= s2_valid_d;
      s2_a_q      <= s2_a_d;
      s2_b_q      <= s2_b_d;
      s2_w_q      <= s2_w_d;
      s2_sel_q    <= s2_sel_d;
      s2_inv_q    <= s2_inv_d;
      out_valid_q <= out_valid_d;
      x_q         <= x_d;
      y_q         <= y_d;
    end
  end

endmodule

// File: tb/tb_ntt_butterfly.sv
// ---------------------------------------------------------------------------
// tb_ntt_butterfly
//   Scoreboard bench for ntt_butterfly. Stimulus pushes the expected {x, y}
//   when a pair is accepted. A monitor on the falling edge pops and compares
//   on every output handshake. Directed checks cover reset, latency,
//   backpressure and reset mid-stream.
// ---------------------------------------------------------------------------
module tb_ntt_butterfly;

  localparam int W = 23;
  localparam longint Q0 = 8380417;
  localparam longint Q1 = 3329;

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] u, v, w;
  logic         sel, inv;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] x, y;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc      = 0;

  ntt_butterfly dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .u_i        (u),
    .v_i        (v),
    .w_i        (w),
    .select_i   (sel),
    .inv_i      (inv),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .x_o        (x),
    .y_o        (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Independent reference written straight from the butterfly equations.
  function automatic exp_t model(input longint mu, mv, mw, input bit msel, minv);
    longint q, t;
    exp_t   e;
    q = msel ? Q1 : Q0;
    if (!minv) begin
      t   = (mv * mw) % q;
      e.x = W'((mu + t) % q);
      e.y = W'((mu - t + q) % q);
    end else begin
      e.x = W'((mu + mv) % q);
      e.y = W'((((mu - mv + q) % q) * mw) % q);
    end
    return e;
  endfunction

  // Monitor: compare on every output handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_output: got x=%0d y=%0d expected none", x, y);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result_x", longint'(x), longint'(e.x));
        check("result_y", longint'(y), longint'(e.y));
      end
    end
  end

  // Present one pair and wait (bounded) for it to be accepted.
  task automatic send(input longint su, sv, sw, input bit ssel, sinv,
                      input longint ex, ey);
    bit   ok;
    exp_t e;
    ok       = 1'b0;
    u        = W'(su);
    v        = W'(sv);
    w        = W'(sw);
    sel      = ssel;
    inv      = sinv;
    in_valid = 1'b1;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
    if (!ok) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 100 cycles");
      in_valid = 1'b0;
      return;
    end
    e.x = W'(ex);
    e.y = W'(ey);
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic send_model(input longint su, sv, sw, input bit ssel, sinv);
    exp_t e;
    e = model(su, sv, sw, ssel, sinv);
    send(su, sv, sw, ssel, sinv, longint'(e.x), longint'(e.y));
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && sb.size() > 0; k++) @(negedge clk);
    check("drain_empty", longint'(sb.size()), 0);
    @(posedge clk);
    #1;
  endtask

  // Mixed-stream table: select and mode cycle through all four combinations.
  longint mu[8]   = '{123456, 1234, 8380000, 3328, 42,      0,    4000000, 1};
  longint mv[8]   = '{654321, 2345, 500,     1,    8380416, 3328, 4380417, 2};
  longint mw[8]   = '{777,    17,   8380416, 3000, 2,       3328, 99999,   3};
  bit     msel[8] = '{0, 1, 0, 1, 0, 1, 0, 1};
  bit     minv[8] = '{0, 0, 1, 1, 0, 0, 1, 1};

  initial begin
    logic [W-1:0] hx, hy;
    int           c0;
    bit           seen;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    u = '0; v = '0; w = '0; sel = 1'b0; inv = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state, with out_ready low to confirm in_ready does not depend on it.
    check("reset_out_valid", longint'(out_valid), 0);
    check("reset_x", longint'(x), 0);
    check("reset_y", longint'(y), 0);
    check("reset_in_ready", longint'(in_ready), 1);
    @(posedge clk);
    #1;

    // Basic vectors and latency: the result must appear on the third edge.
    out_ready = 1'b1;
    send(5, 3, 2, 1'b0, 1'b0, 11, 8380416);
    idle();
    @(posedge clk); #1;
    check("latency_not_early", longint'(out_valid), 0);
    @(posedge clk); #1;
    check("latency_exact", longint'(out_valid), 1);
    send(3000, 1000, 1, 1'b1, 1'b0, 671, 2000);
    send(1, 2, 3, 1'b0, 1'b1, 3, 8380414);
    idle();
    drain();

    // Backpressure: five back-to-back pairs, output held for four cycles.
    out_ready = 1'b0;
    fork
      begin
        send(10,      20,   3,    1'b1, 1'b0, 70,  3279);
        send(100,     200,  2,    1'b1, 1'b1, 300, 3129);
        send(8380416, 1,    1,    1'b0, 1'b0, 0,   8380415);
        send(0,       0,    5,    1'b0, 1'b1, 0,   0);
        send(3328,    3328, 3328, 1'b1, 1'b0, 0,   3327);
        idle();
      end
      begin
        seen = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
          @(negedge clk);
          if (out_valid) seen = 1'b1;
        end
        check("bp_first_result_seen", longint'(seen), 1);
        hx = x;
        hy = y;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          check("bp_in_ready_low", longint'(in_ready), 0);
          check("bp_valid_held", longint'(out_valid), 1);
          check("bp_x_stable", longint'(x), longint'(hx));
          check("bp_y_stable", longint'(y), longint'(hy));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Mixed stream at full rate: one acceptance per cycle, no stalls.
    out_ready = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 8; i++) send_model(mu[i], mv[i], mw[i], msel[i], minv[i]);
    check("mixed_one_per_cycle", longint'(cyc - c0), 8);
    idle();
    drain();

    // Reset mid-stream with three pairs in flight.
    send(5, 3, 2, 1'b0, 1'b0, 11, 8380416);
    send(6, 1, 1, 1'b0, 1'b0, 7, 5);
    send(9, 2, 2, 1'b0, 1'b1, 11, 14);
    idle();
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", longint'(out_valid), 0);
    check("midrst_x", longint'(x), 0);
    check("midrst_y", longint'(y), 0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(7, 4, 10, 1'b0, 1'b0, 47, 8380384);
    idle();
    @(posedge clk); #1;
    check("post_rst_not_early", longint'(out_valid), 0);
    @(posedge clk); #1;
    check("post_rst_latency", longint'(out_valid), 1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
